// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared types and helpers for the writeback/load-store stage
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  // A doubleword access on a 32-bit datapath degrades to a word access.
  function automatic mem_size_e clamp_size(input logic [1:0] size, input int word_width);
    if (size == 2'd3 && word_width == 32) return MEM_W;
    return mem_size_e'(size);
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-enable generation, store lane replication, load extraction/extension
module lsu_data_align
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = 32,
  localparam int BE_WIDTH = WORD_WIDTH / 8,
  localparam int OFF_WIDTH = $clog2(BE_WIDTH)
) (
  input  mem_size_e             size_i,
  input  logic [OFF_WIDTH-1:0]  offset_i,
  input  logic                  sign_ext_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  input  logic [WORD_WIDTH-1:0] rdata_i,
  output logic [BE_WIDTH-1:0]   be_o,
  output logic [WORD_WIDTH-1:0] wdata_o,
  output logic [WORD_WIDTH-1:0] load_data_o
);

  logic [WORD_WIDTH-1:0] shifted;
  int nbytes;
  int nbits;

  always_comb begin
    nbytes = 1 << size_i;
    nbits  = nbytes * 8;
    be_o    = '0;
    wdata_o = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (i >= int'(offset_i) && i < int'(offset_i) + nbytes) be_o[i] = 1'b1;
      wdata_o[i*8 +: 8] = store_data_i[(i % nbytes)*8 +: 8];
    end
    // Bring the addressed lane down to bit 0, then mask and extend to the access size.
    shifted = rdata_i >> {offset_i, 3'b000};
    load_data_o = '0;
    for (int j = 0; j < WORD_WIDTH; j++) begin
      if (j < nbits) load_data_o[j] = shifted[j];
      else           load_data_o[j] = sign_ext_i & shifted[nbits-1];
    end
  end

endmodule

// File: rtl/wb_lsu_stage.sv
// rtl/wb_lsu_stage.sv - writeback stage with load/store unit; WB_LSU_MISALIGN_TRAP_EN enables misalign trap
module wb_lsu_stage
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  localparam int BE_WIDTH   = WORD_WIDTH / 8,
  localparam int OFF_WIDTH  = $clog2(BE_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic                   ex_mem_i,
  input  logic                   ex_we_i,
  input  logic [1:0]             ex_size_i,
  input  logic                   ex_sign_ext_i,
  input  logic [WORD_WIDTH-1:0]  ex_result_i,
  input  logic [WORD_WIDTH-1:0]  ex_store_data_i,
  input  logic [RADDR_WIDTH-1:0] ex_rd_addr_i,
  output logic                   wb_valid_o,
  output logic [RADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [WORD_WIDTH-1:0]  wb_data_o,
  output logic                   data_req_o,
  output logic [ADDR_WIDTH-1:0]  data_addr_o,
  output logic                   data_we_o,
  output logic [BE_WIDTH-1:0]    data_be_o,
  output logic [WORD_WIDTH-1:0]  data_wdata_o,
  input  logic [WORD_WIDTH-1:0]  data_rdata_i,
  input  logic                   data_rvalid_i,
  input  logic                   data_gnt_i,
  output logic                   misalign_o,
  output logic                   busy_o
);

  lsu_state_e             state_q;
  logic                   req_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  mem_size_e              size_q;
  logic [OFF_WIDTH-1:0]   off_q;
  logic                   sign_q;
  logic [WORD_WIDTH-1:0]  sdata_q;
  logic [RADDR_WIDTH-1:0] rd_q;
  logic                   wb_valid_q;
  logic [RADDR_WIDTH-1:0] wb_rd_q;
  logic [WORD_WIDTH-1:0]  wb_data_q;

  mem_size_e             eff_size;
  logic [OFF_WIDTH-1:0]  raw_off;
  logic [OFF_WIDTH-1:0]  size_mask;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [BE_WIDTH-1:0]   be;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] load_data;
  logic                  accept;

  assign eff_size  = clamp_size(ex_size_i, WORD_WIDTH);
  assign acc_addr  = ADDR_WIDTH'(ex_result_i);
  assign raw_off   = acc_addr[OFF_WIDTH-1:0];
  assign size_mask = OFF_WIDTH'((32'd1 << eff_size) - 32'd1);
  assign accept    = ex_valid_i & ex_ready_o;

`ifdef WB_LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  logic misaligned;
  assign misaligned = |(raw_off & size_mask);
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  lsu_data_align #(.WORD_WIDTH(WORD_WIDTH)) u_align (
    .size_i       (size_q),
    .offset_i     (off_q),
    .sign_ext_i   (sign_q),
    .store_data_i (sdata_q),
    .rdata_i      (data_rdata_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= MEM_B;
      off_q      <= '0;
      sign_q     <= 1'b0;
      sdata_q    <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
`ifdef WB_LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
`ifdef WB_LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept && !ex_mem_i) begin
            if (ex_rd_addr_i != '0) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= ex_rd_addr_i;
              wb_data_q  <= ex_result_i;
            end
          end else if (accept) begin
`ifdef WB_LSU_MISALIGN_TRAP_EN
            if (misaligned) begin
              misalign_q <= 1'b1;
            end else begin
`else
            begin
`endif
              state_q <= WAIT_GNT;
              req_q   <= 1'b1;
              addr_q  <= {acc_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
              we_q    <= ex_we_i;
              size_q  <= eff_size;
              off_q   <= raw_off & ~size_mask;
              sign_q  <= ex_sign_ext_i;
              sdata_q <= ex_store_data_i;
              rd_q    <= ex_rd_addr_i;
            end
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state_q <= IDLE;
            if (!we_q && rd_q != '0) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= load_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready_o   = (state_q == IDLE) & ~rst_i;
  assign busy_o       = (state_q != IDLE);
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = req_q ? be : '0;
  assign data_wdata_o = wdata;

endmodule

// File: tb/tb_wb_lsu_stage.sv
// tb/tb_wb_lsu_stage.sv - directed self-checking bench for wb_lsu_stage (honours WB_LSU_MISALIGN_TRAP_EN)
module tb_wb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_mem, ex_we, ex_sign;
  logic [1:0]  ex_size;
  logic [31:0] ex_result, ex_sdata;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        req, we, rvalid, gnt, misalign, busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_lsu_stage dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_mem_i(ex_mem), .ex_we_i(ex_we),
    .ex_size_i(ex_size), .ex_sign_ext_i(ex_sign), .ex_result_i(ex_result),
    .ex_store_data_i(ex_sdata), .ex_rd_addr_i(ex_rd),
    .wb_valid_o(wb_valid), .wb_rd_addr_o(wb_rd), .wb_data_o(wb_data),
    .data_req_o(req), .data_addr_o(addr), .data_we_o(we), .data_be_o(be),
    .data_wdata_o(wdata), .data_rdata_i(rdata), .data_rvalid_i(rvalid),
    .data_gnt_i(gnt), .misalign_o(misalign), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic mem, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem = mem; ex_we = w; ex_size = sz; ex_sign = sg;
    ex_result = res; ex_sdata = sd; ex_rd = rd;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_mem = 1'b0; ex_we = 1'b0; ex_size = 2'd0; ex_sign = 1'b0;
    ex_result = '0; ex_sdata = '0; ex_rd = '0; rvalid = 1'b0; gnt = 1'b0; rdata = '0;
    step(); step();
    check("rst_ready", ex_ready, 0);
    check("rst_req", req, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1 check("ready_after_rst", ex_ready, 1);

    // 1: ALU op
    issue(0, 0, 2'd2, 0, 32'hDEADBEEF, 0, 5'd5);
    step(); ex_valid = 1'b0;
    check("alu_wbv", wb_valid, 1);
    check("alu_rd", wb_rd, 5);
    check("alu_data", wb_data, 32'hDEADBEEF);
    check("alu_busy", busy, 0);
    step();
    check("alu_pulse", wb_valid, 0);

    // 2: LB signed 0x1003, immediate grant
    issue(1, 0, 2'd0, 1, 32'h1003, 0, 5'd7);
    step(); ex_valid = 1'b0;
    check("lb_req", req, 1);
    check("lb_addr", addr, 32'h1000);
    check("lb_be", be, 4'b1000);
    check("lb_we", we, 0);
    check("lb_ready", ex_ready, 0);
    gnt = 1'b1;
    step(); gnt = 1'b0;
    check("lb_req_drop", req, 0);
    check("lb_no_wb_early", wb_valid, 0);
    rvalid = 1'b1; rdata = 32'h80FFFF7F;
    step(); rvalid = 1'b0;
    check("lb_wbv", wb_valid, 1);
    check("lb_data", wb_data, 32'hFFFFFF80);
    check("lb_rd", wb_rd, 7);
    check("lb_ready_back", ex_ready, 1);

    // 3: SH 0x2002, grant delayed four cycles
    issue(1, 1, 2'd1, 0, 32'h2002, 32'h1234, 5'd9);
    step(); ex_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sh_req%0d", k), req, 1);
      check($sformatf("sh_addr%0d", k), addr, 32'h2000);
      check($sformatf("sh_be%0d", k), be, 4'b1100);
      check($sformatf("sh_wdata%0d", k), wdata, 32'h12341234);
      check($sformatf("sh_we%0d", k), we, 1);
      if (k == 4) gnt = 1'b1;
      step();
    end
    gnt = 1'b0;
    check("sh_req_drop", req, 0);
    check("sh_ready_wait", ex_ready, 0);
    rvalid = 1'b1;
    step(); rvalid = 1'b0;
    check("sh_no_wb", wb_valid, 0);
    check("sh_ready_back", ex_ready, 1);
    check("sh_wb_hold", wb_data, 32'hFFFFFF80);

    // 4: spurious rvalid in IDLE alongside an ALU op
    rvalid = 1'b1; rdata = 32'h11111111;
    issue(0, 0, 2'd2, 0, 32'h55, 0, 5'd3);
    step(); ex_valid = 1'b0; rvalid = 1'b0;
    check("spur_wbv", wb_valid, 1);
    check("spur_data", wb_data, 32'h55);
    check("spur_busy", busy, 0);
    check("spur_req", req, 0);

    // LHU 0x5002, unsigned half from upper lanes
    issue(1, 0, 2'd1, 0, 32'h5002, 0, 5'd8);
    step(); ex_valid = 1'b0;
    check("lhu_be", be, 4'b1100);
    gnt = 1'b1; step(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h87654321;
    step(); rvalid = 1'b0;
    check("lhu_data", wb_data, 32'h00008765);

    // 5: reset while waiting for rvalid
    issue(1, 0, 2'd2, 0, 32'h4000, 0, 5'd4);
    step(); ex_valid = 1'b0;
    gnt = 1'b1; step(); gnt = 1'b0;
    check("rst5_busy", busy, 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("rst5_idle", busy, 0);
    check("rst5_req", req, 0);
    rvalid = 1'b1; rdata = 32'hA5A5A5A5;
    step(); rvalid = 1'b0;
    check("rst5_no_wb", wb_valid, 0);
    check("rst5_ready", ex_ready, 1);
    check("rst5_busy2", busy, 0);

    // 6: LW misaligned 0x3002
    issue(1, 0, 2'd2, 0, 32'h3002, 0, 5'd6);
    step(); ex_valid = 1'b0;
`ifdef WB_LSU_MISALIGN_TRAP_EN
    check("mis_pulse", misalign, 1);
    check("mis_req", req, 0);
    check("mis_wbv", wb_valid, 0);
    check("mis_busy", busy, 0);
    step();
    check("mis_pulse_end", misalign, 0);
`else
    check("mis_tied", misalign, 0);
    check("mis_req", req, 1);
    check("mis_addr", addr, 32'h3000);
    check("mis_be", be, 4'hF);
    gnt = 1'b1; step(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFEF00D;
    step(); rvalid = 1'b0;
    check("mis_wbv", wb_valid, 1);
    check("mis_data", wb_data, 32'hCAFEF00D);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
